// File: rtl/i2c_slave_regfile.sv
//============================================================================
// Module   : i2c_slave_regfile
// Purpose  : I2C slave with an 8-bit register file. A write sets a register
//            pointer and then stores data bytes. A read returns bytes from
//            the pointer. The pointer auto-increments with wrap and persists
//            across transactions. SCL and SDA are oversampled on clk.
// Options  : define I2C_SLAVE_CLK_STRETCH_EN to add the stretch_req input.
//            With it set, SCL is held low after an ACK bit while the local
//            side asks for more time.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          scl_oe,
  output logic          sda_oe,
  input  logic [PW-1:0] loc_addr,
  output logic [7:0]    loc_rdata,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  input  logic          stretch_req,
`endif
  output logic          bus_busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  state_t                 state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;

  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [7:0]             shift_byte;
  logic                   rw_q, rw_d;
  logic                   ack_q, ack_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic [PW-1:0]          ptr_q, ptr_d, ptr_inc;
  logic                   wr_valid_q, wr_valid_d;
  logic [PW-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   reg_we;
  logic [7:0]             regs_q [NUM_REGS];

  // Bring the raw bus levels into the clk domain; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise =  scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s &  scl_prev_q;
  assign sda_rise =  sda_s & ~sda_prev_q;
  assign sda_fall = ~sda_s &  sda_prev_q;

  // The SCL level after any same-clk SCL edge qualifies START/STOP, so an
  // SCL edge coinciding with an SDA edge is treated as having happened first.
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  assign shift_byte = {shreg_q[6:0], sda_s};
  assign ptr_inc    = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

  // Protocol sequencer: SCL-edge work first, then START/STOP override control
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;

    case (state_q)
      ST_ADDR: begin
        if (scl_rise && bitcnt_q < 4'd8) begin
          shreg_d  = shift_byte;
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (scl_fall && bitcnt_q == 4'd8) begin
          bitcnt_d = 4'd0;
          if (shreg_q[7:1] == SLAVE_ADDR) begin
            rw_d     = shreg_q[0];
            sda_oe_d = 1'b1;
            state_d  = ST_ADDR_ACK;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WAIT_STOP;
          end
        end
      end

      ST_ADDR_ACK: begin
        if (scl_fall) begin
          bitcnt_d = 4'd0;
          if (rw_q) begin
            shreg_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            state_d  = ST_RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_PTR;
          end
        end
      end

      ST_PTR: begin
        if (scl_rise && bitcnt_q < 4'd8) begin
          shreg_d  = shift_byte;
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (scl_fall && bitcnt_q == 4'd8) begin
          bitcnt_d = 4'd0;
          // Out-of-range pointers are refused and leave the pointer alone
          if ({1'b0, shreg_q} < 9'(NUM_REGS)) begin
            ptr_d    = shreg_q[PW-1:0];
            sda_oe_d = 1'b1;
            state_d  = ST_PTR_ACK;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WAIT_STOP;
          end
        end
      end

      ST_PTR_ACK, ST_WDATA_ACK: begin
        if (scl_fall) begin
          bitcnt_d = 4'd0;
          sda_oe_d = 1'b0;
          state_d  = ST_WDATA;
        end
      end

      ST_WDATA: begin
        if (scl_rise && bitcnt_q < 4'd8) begin
          shreg_d  = shift_byte;
          bitcnt_d = bitcnt_q + 4'd1;
          // The byte lands on its 8th bit; an unfinished byte never writes
          if (bitcnt_q == 4'd7) begin
            reg_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_byte;
            ptr_d      = ptr_inc;
          end
        end else if (scl_fall && bitcnt_q == 4'd8) begin
          bitcnt_d = 4'd0;
          sda_oe_d = 1'b1;
          state_d  = ST_WDATA_ACK;
        end
      end

      ST_RDATA: begin
        if (scl_rise && bitcnt_q < 4'd8) begin
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            state_d  = ST_RDATA_ACK;
          end else if (bitcnt_q != 4'd0) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
      end

      ST_RDATA_ACK: begin
        if (scl_rise) begin
          // The byte has been consumed whether or not the master ACKs it
          ack_d = ~sda_s;
          ptr_d = ptr_inc;
        end else if (scl_fall) begin
          bitcnt_d = 4'd0;
          if (ack_q) begin
            shreg_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            state_d  = ST_RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WAIT_STOP;
          end
        end
      end

      default: begin
        // IDLE and WAIT_STOP only react to START/STOP below
      end
    endcase

    if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  // State, datapath and register file storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 4'd0;
      shreg_q    <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (reg_we) begin
        regs_q[ptr_q] <= shift_byte;
      end
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic scl_oe_q, scl_oe_d;
  logic ack_end;

  assign ack_end = scl_fall && (state_q == ST_ADDR_ACK  || state_q == ST_PTR_ACK ||
                                state_q == ST_WDATA_ACK || state_q == ST_RDATA_ACK);

  // Hold SCL low from the end of an ACK bit until the local side is ready
  always_comb begin
    scl_oe_d = scl_oe_q;
    if (scl_oe_q) begin
      scl_oe_d = stretch_req;
    end else if (ack_end && stretch_req) begin
      scl_oe_d = 1'b1;
    end
  end

  // Stretch flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_oe_q <= 1'b0;
    end else begin
      scl_oe_q <= scl_oe_d;
    end
  end

  assign scl_oe = scl_oe_q;
`else
  assign scl_oe = 1'b0;
`endif

  assign sda_oe    = sda_oe_q;
  assign bus_busy  = busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign loc_rdata = (int'(loc_addr) < NUM_REGS) ? regs_q[loc_addr] : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
//============================================================================
// Module   : tb_i2c_slave_regfile
// Purpose  : Bus-level bench for i2c_slave_regfile. A bit-banged master
//            drives an open-drain bus. A register-file model predicts ACKs,
//            read bytes and write strobes, which monitors compare as the
//            DUT produces them.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave_regfile;

  localparam logic [6:0] SLAVE_ADDR = 7'h50;
  localparam int         NUM_REGS   = 16;
  localparam int         PW         = 4;
  localparam int         Q          = 6;   // clks per quarter SCL period

  logic          clk = 1'b0;
  logic          rst;
  logic          m_scl_low, m_sda_low;
  logic          scl_oe, sda_oe, scl_bus, sda_bus;
  logic [PW-1:0] loc_addr;
  logic [7:0]    loc_rdata;
  logic          wr_valid;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          bus_busy;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic          stretch_req;
  int            hi_cnt;
  int            st_t;
`else
  int            scl_oe_seen = 0;
`endif

  always #5 clk = ~clk;

  assign scl_bus = ~(m_scl_low | scl_oe);
  assign sda_bus = ~(m_sda_low | sda_oe);

  i2c_slave_regfile #(
    .SLAVE_ADDR (SLAVE_ADDR),
    .NUM_REGS   (NUM_REGS),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_bus),
    .sda_in     (sda_bus),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .loc_addr   (loc_addr),
    .loc_rdata  (loc_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    .stretch_req(stretch_req),
`endif
    .bus_busy   (bus_busy)
  );

  typedef struct packed { logic [1:0] kind; logic [7:0] val; } bus_item_t;
  typedef struct packed { logic [PW-1:0] addr; logic [7:0] data; } wr_item_t;

  bus_item_t  exp_bus_q[$];
  bus_item_t  obs_bus_q[$];
  wr_item_t   exp_wr_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] m_regs [NUM_REGS];
  int         m_ptr;
  logic [7:0] tx_buf [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Write-strobe monitor
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      if (exp_wr_q.size() == 0) begin
        chk("unexpected wr_valid", 32'd1, 32'd0);
      end else begin
        wr_item_t e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  // Bus-response monitor: pairs predicted and observed ACKs / read bytes
  always @(negedge clk) begin
    while (exp_bus_q.size() > 0 && obs_bus_q.size() > 0) begin
      bus_item_t e, o;
      e = exp_bus_q.pop_front();
      o = obs_bus_q.pop_front();
      chk((e.kind == 2'd0) ? "ack bit" : "read byte", 32'({o.kind, o.val}), 32'({e.kind, e.val}));
    end
  end

`ifndef I2C_SLAVE_CLK_STRETCH_EN
  always @(negedge clk) begin
    if (scl_oe) scl_oe_seen++;
  end
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic scl_release();
    int t;
    t = 0;
    m_scl_low = 1'b0;
    @(negedge clk);
    while (scl_bus !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (scl_bus !== 1'b1) chk("scl release timeout", 32'd0, 32'd1);
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b;
    tick(Q);
    scl_release();
    tick(2*Q);
    m_scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0;
    tick(Q);
    scl_release();
    tick(Q);
    b = sda_bus;
    tick(Q);
    m_scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    tick(Q);
    scl_release();
    tick(Q);
    m_sda_low = 1'b1;
    tick(Q);
    m_scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    tick(Q);
    scl_release();
    tick(Q);
    m_sda_low = 1'b0;
    tick(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    logic a;
    exp_bus_q.push_back(bus_item_t'({2'd0, 7'd0, exp_ack}));
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    obs_bus_q.push_back(bus_item_t'({2'd0, 7'd0, ~a}));
  endtask

  task automatic read_byte(input logic [7:0] exp_val, input logic ack);
    logic [7:0] v;
    logic       bb;
    exp_bus_q.push_back(bus_item_t'({2'd1, exp_val}));
    for (int i = 7; i >= 0; i--) begin
      get_bit(bb);
      v[i] = bb;
    end
    obs_bus_q.push_back(bus_item_t'({2'd1, v}));
    put_bit(~ack);
  endtask

  // Write transaction: first byte is the pointer, the rest are data
  task automatic wr_txn(input logic [6:0] a, input int n, input bit do_stop);
    bit         live;
    bit         exp_ack;
    logic [7:0] b;
    i2c_start();
    live = (a == SLAVE_ADDR);
    send_byte({a, 1'b0}, live);
    for (int i = 0; i < n; i++) begin
      b       = tx_buf[i];
      exp_ack = 1'b0;
      if (live) begin
        if (i == 0) begin
          if (int'(b) < NUM_REGS) begin
            m_ptr   = int'(b);
            exp_ack = 1'b1;
          end else begin
            live = 1'b0;
          end
        end else begin
          m_regs[m_ptr] = b;
          exp_wr_q.push_back(wr_item_t'({PW'(m_ptr), b}));
          m_ptr   = (m_ptr + 1) % NUM_REGS;
          exp_ack = 1'b1;
        end
      end
      send_byte(b, exp_ack);
    end
    if (do_stop) i2c_stop();
  endtask

  // Read transaction: ACK every byte but the last, then STOP
  task automatic rd_txn(input logic [6:0] a, input int n);
    bit         live;
    logic [7:0] e;
    i2c_start();
    live = (a == SLAVE_ADDR);
    send_byte({a, 1'b1}, live);
    for (int i = 0; i < n; i++) begin
      if (live) begin
        e     = m_regs[m_ptr];
        m_ptr = (m_ptr + 1) % NUM_REGS;
      end else begin
        e = 8'hFF;
      end
      read_byte(e, i < n - 1);
    end
    i2c_stop();
  endtask

  task automatic chk_reg(input string name, input int idx, input logic [7:0] exp);
    loc_addr = PW'(idx);
    #1;
    chk(name, 32'(loc_rdata), 32'(exp));
  endtask

  initial begin
    rst       = 1'b1;
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    loc_addr  = '0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    stretch_req = 1'b0;
    hi_cnt      = 0;
`endif
    model_reset();
    tick(5);

    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset scl_oe", 32'(scl_oe), 32'd0);
    chk("reset wr_valid", 32'(wr_valid), 32'd0);
    chk("reset bus_busy", 32'(bus_busy), 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    chk("reset wr_data", 32'(wr_data), 32'd0);
    chk_reg("reset reg0", 0, 8'h00);
    rst = 1'b0;
    tick(5);

    // Basic write of two data bytes from pointer 3
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    wr_txn(SLAVE_ADDR, 3, 1'b1);
    chk_reg("reg3 after write", 3, 8'h11);
    chk_reg("reg4 after write", 4, 8'h22);
    chk("bus_busy after stop", 32'(bus_busy), 32'd0);

    // Seed reg5 so the post-read pointer position is observable
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h5A;
    wr_txn(SLAVE_ADDR, 2, 1'b1);

    // Pointer write, repeated START, read two bytes, then read at ptr 5
    tx_buf[0] = 8'h03;
    wr_txn(SLAVE_ADDR, 1, 1'b0);
    rd_txn(SLAVE_ADDR, 2);
    rd_txn(SLAVE_ADDR, 1);

    // Foreign address: no ACK, no writes, busy until STOP
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h77;
    wr_txn(7'h52, 2, 1'b0);
    chk("bus_busy foreign addr", 32'(bus_busy), 32'd1);
    i2c_stop();
    tick(4);
    chk("bus_busy after foreign stop", 32'(bus_busy), 32'd0);
    chk_reg("reg2 untouched", 2, 8'h00);

    // Out-of-range pointer refused; pointer stays where the read left it
    tx_buf[0] = 8'h10; tx_buf[1] = 8'h99; tx_buf[2] = 8'h98;
    wr_txn(SLAVE_ADDR, 3, 1'b1);
    rd_txn(SLAVE_ADDR, 1);

    // Pointer wrap from the last register to register 0
    tx_buf[0] = 8'h0F; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
    wr_txn(SLAVE_ADDR, 3, 1'b1);
    chk_reg("reg15 wrap write", 15, 8'hAA);
    chk_reg("reg0 wrap write", 0, 8'hBB);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // Stretch after the address ACK for about 50 clks
    stretch_req = 1'b1;
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h3C;
    fork
      wr_txn(SLAVE_ADDR, 2, 1'b1);
      begin
        st_t = 0;
        while (scl_oe !== 1'b1 && st_t < 2000) begin
          @(negedge clk);
          st_t++;
        end
        chk("stretch started", 32'(scl_oe), 32'd1);
        tick(50);
        stretch_req = 1'b0;
      end
      begin
        repeat (1500) begin
          @(negedge clk);
          if (scl_oe) hi_cnt++;
        end
      end
    join
    chk("stretch length", 32'(hi_cnt >= 49 && hi_cnt <= 53), 32'd1);
    chk_reg("reg1 after stretch", 1, 8'h3C);
`endif

    // Reset in the middle of an address byte; bus ignored until next START
    i2c_start();
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    chk("bus_busy after mid reset", 32'(bus_busy), 32'd0);
    send_byte(8'h06, 1'b0);
    i2c_stop();
    chk_reg("reg15 cleared by reset", 15, 8'h00);

    // Randomized mix of writes and reads
    for (int it = 0; it < 24; it++) begin
      logic [6:0] a;
      int         n;
      a = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 4);
        tx_buf[0] = 8'($urandom_range(0, 19));
        for (int k = 1; k < n; k++) tx_buf[k] = 8'($urandom);
        wr_txn(a, n, 1'b1);
      end else begin
        rd_txn(a, $urandom_range(1, 3));
      end
    end

    tick(20);
    for (int i = 0; i < NUM_REGS; i++) chk_reg("final reg sweep", i, m_regs[i]);
    chk("pending write strobes", 32'(exp_wr_q.size()), 32'd0);
    chk("pending bus responses", 32'(exp_bus_q.size()), 32'(obs_bus_q.size()));
`ifndef I2C_SLAVE_CLK_STRETCH_EN
    chk("scl_oe never driven", 32'(scl_oe_seen), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
